// File: rtl/uc_cndjmp_issue.sv
// Conditional-jump issue unit: accepts a jump from decode, resolves the
// condition against flags captured at acceptance, then drives a one-cycle
// PC load/flush and a flush hold window before accepting the next jump.
module uc_cndjmp_issue #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jmp_valid,
    output logic              jmp_ready,
    input  logic [2:0]        jmp_cond,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [3:0]        flags,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_req,
    output logic              condjmp_hold,
    input  logic              clr_stats,
    output logic [7:0]        taken_cnt,
    output logic [7:0]        nottaken_cnt
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STAT_W = 8;

    // Flag bit positions within {N,V,C,Z}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_LOAD    = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         cond_q;
    logic [3:0]         flags_q;
    logic [CNT_W-1:0]   hold_cnt;
    logic               accept;
    logic               taken;
    logic               resolve_taken;
    logic               resolve_nottaken;

    // Handshake and resolve-edge qualifiers
    always_comb begin
        accept           = 1'b0;
        resolve_taken    = 1'b0;
        resolve_nottaken = 1'b0;
        accept           = jmp_valid && (state == S_IDLE);
        resolve_taken    = (state == S_RESOLVE) && taken;
        resolve_nottaken = (state == S_RESOLVE) && !taken;
    end

    // Condition evaluation on the flags captured at acceptance
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            3'b000:  taken = 1'b1;
            3'b001:  taken = flags_q[FLAG_Z];
            3'b010:  taken = !flags_q[FLAG_Z];
            3'b011:  taken = flags_q[FLAG_C];
            3'b100:  taken = !flags_q[FLAG_C];
            3'b101:  taken = flags_q[FLAG_N];
            3'b110:  taken = flags_q[FLAG_V];
            default: taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                state_nxt = taken ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                state_nxt = (FLUSH_CYCLES != 0) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                // Leave on the last hold cycle; a zero count also exits
                if (hold_cnt <= CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: every output is a pure function of the state register
    always_comb begin
        jmp_ready    = 1'b0;
        pc_load      = 1'b0;
        flush_req    = 1'b0;
        condjmp_hold = 1'b0;
        jmp_ready    = (state == S_IDLE);
        pc_load      = (state == S_LOAD);
        flush_req    = (state == S_LOAD);
        condjmp_hold = (state != S_IDLE);
    end

    // Capture condition, flags and target on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_q    <= 3'd0;
            flags_q   <= 4'd0;
            pc_target <= '0;
        end else if (accept) begin
            cond_q    <= jmp_cond;
            flags_q   <= flags;
            pc_target <= jmp_target;
        end
    end

    // Flush hold down counter, loaded as the FSM enters LOAD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (resolve_taken) begin
            hold_cnt <= CNT_W'(FLUSH_CYCLES);
        end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end

    // Saturating statistics; clear wins over a coincident increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (clr_stats) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else begin
            if (resolve_taken && (taken_cnt != {STAT_W{1'b1}})) begin
                taken_cnt <= taken_cnt + STAT_W'(1);
            end
            if (resolve_nottaken && (nottaken_cnt != {STAT_W{1'b1}})) begin
                nottaken_cnt <= nottaken_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uc_cndjmp_issue.sv
// Directed bench for uc_cndjmp_issue: default FLUSH_CYCLES=2 instance plus
// a FLUSH_CYCLES=0 instance sharing data inputs and reset.
module tb_uc_cndjmp_issue;

    logic        clk;
    logic        reset_n;
    logic        jmp_valid;
    logic        jmp_valid_z;
    logic [2:0]  jmp_cond;
    logic [15:0] jmp_target;
    logic [3:0]  flags;
    logic        clr_stats;

    logic        jmp_ready,   jmp_ready_z;
    logic        pc_load,     pc_load_z;
    logic [15:0] pc_target,   pc_target_z;
    logic        flush_req,   flush_req_z;
    logic        condjmp_hold, condjmp_hold_z;
    logic [7:0]  taken_cnt,   taken_cnt_z;
    logic [7:0]  nottaken_cnt, nottaken_cnt_z;

    int n_cmp;
    int n_err;

    // Vector: {expected taken, cond[2:0], flags[3:0]}
    localparam int unsigned NVEC = 13;
    localparam logic [7:0] VEC [NVEC] = '{
        8'h80, 8'h10, 8'h91, 8'hA0, 8'hB2, 8'h30, 8'h42,
        8'hCD, 8'hD8, 8'h57, 8'hE4, 8'h6B, 8'h7F
    };

    logic [7:0]  v;
    logic        saw;
    logic [15:0] tl;
    logic [15:0] t;
    int          cyc;
    int          exp_t;
    int          exp_nt;
    int          acc;
    int          loads;
    int          last_acc;

    uc_cndjmp_issue #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .jmp_valid    (jmp_valid),
        .jmp_ready    (jmp_ready),
        .jmp_cond     (jmp_cond),
        .jmp_target   (jmp_target),
        .flags        (flags),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .flush_req    (flush_req),
        .condjmp_hold (condjmp_hold),
        .clr_stats    (clr_stats),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
    );

    uc_cndjmp_issue #(.ADDR_W(16), .FLUSH_CYCLES(0)) dut_z (
        .clk          (clk),
        .reset_n      (reset_n),
        .jmp_valid    (jmp_valid_z),
        .jmp_ready    (jmp_ready_z),
        .jmp_cond     (jmp_cond),
        .jmp_target   (jmp_target),
        .flags        (flags),
        .pc_load      (pc_load_z),
        .pc_target    (pc_target_z),
        .flush_req    (flush_req_z),
        .condjmp_hold (condjmp_hold_z),
        .clr_stats    (clr_stats),
        .taken_cnt    (taken_cnt_z),
        .nottaken_cnt (nottaken_cnt_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bounded wait for the main instance to return to IDLE
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!jmp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!jmp_ready) chk({tag, "_timeout"}, 32'(jmp_ready), 32'd1);
    endtask

    // One jump on the main instance, called at a negedge while IDLE.
    // Flags are inverted right after acceptance to prove they were captured.
    task automatic run_jump(input logic [2:0] c, input logic [3:0] f, input logic [15:0] tg,
                            output logic s, output logic [15:0] tload, output int cy);
        s     = 1'b0;
        tload = '0;
        jmp_cond   = c;
        flags      = f;
        jmp_target = tg;
        jmp_valid  = 1'b1;
        @(negedge clk);
        jmp_valid = 1'b0;
        flags     = ~f;
        cy        = 1;
        while (!jmp_ready && cy < 50) begin
            if (pc_load) begin
                s     = 1'b1;
                tload = pc_target;
            end
            @(negedge clk);
            cy++;
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        jmp_valid   = 1'b0;
        jmp_valid_z = 1'b0;
        jmp_cond    = 3'd0;
        jmp_target  = 16'd0;
        flags       = 4'd0;
        clr_stats   = 1'b0;

        // Reset state
        #3;
        chk("rst_pc_load",  32'(pc_load), 32'd0);
        chk("rst_flush",    32'(flush_req), 32'd0);
        chk("rst_hold",     32'(condjmp_hold), 32'd0);
        chk("rst_target",   32'(pc_target), 32'd0);
        chk("rst_taken",    32'(taken_cnt), 32'd0);
        chk("rst_nottaken", 32'(nottaken_cnt), 32'd0);
        chk("rst_ready",    32'(jmp_ready), 32'd1);

        // Taken jump: cond Z with Z=1, target 0x1234
        @(negedge clk);
        reset_n    = 1'b1;
        jmp_cond   = 3'b001;
        flags      = 4'b0001;
        jmp_target = 16'h1234;
        jmp_valid  = 1'b1;
        chk("tk_k_ready", 32'(jmp_ready), 32'd1);
        @(negedge clk);
        jmp_valid = 1'b0;
        flags     = 4'b0000;
        chk("tk_k1_hold",  32'(condjmp_hold), 32'd1);
        chk("tk_k1_load",  32'(pc_load), 32'd0);
        chk("tk_k1_ready", 32'(jmp_ready), 32'd0);
        @(negedge clk);
        chk("tk_k2_load",   32'(pc_load), 32'd1);
        chk("tk_k2_flush",  32'(flush_req), 32'd1);
        chk("tk_k2_target", 32'(pc_target), 32'h1234);
        chk("tk_k2_hold",   32'(condjmp_hold), 32'd1);
        @(negedge clk);
        chk("tk_k3_load",  32'(pc_load), 32'd0);
        chk("tk_k3_flush", 32'(flush_req), 32'd0);
        chk("tk_k3_hold",  32'(condjmp_hold), 32'd1);
        @(negedge clk);
        chk("tk_k4_hold",  32'(condjmp_hold), 32'd1);
        chk("tk_k4_ready", 32'(jmp_ready), 32'd0);
        @(negedge clk);
        chk("tk_k5_hold",   32'(condjmp_hold), 32'd0);
        chk("tk_k5_ready",  32'(jmp_ready), 32'd1);
        chk("tk_taken",     32'(taken_cnt), 32'd1);
        chk("tk_nottaken",  32'(nottaken_cnt), 32'd0);
        chk("tk_target_hold", 32'(pc_target), 32'h1234);

        // Not-taken jump: cond !Z with Z=1
        jmp_cond   = 3'b010;
        flags      = 4'b0001;
        jmp_target = 16'h0F0F;
        jmp_valid  = 1'b1;
        @(negedge clk);
        jmp_valid = 1'b0;
        chk("nt_k1_hold", 32'(condjmp_hold), 32'd1);
        chk("nt_k1_load", 32'(pc_load), 32'd0);
        @(negedge clk);
        chk("nt_k2_hold",     32'(condjmp_hold), 32'd0);
        chk("nt_k2_ready",    32'(jmp_ready), 32'd1);
        chk("nt_k2_load",     32'(pc_load), 32'd0);
        chk("nt_nottaken",    32'(nottaken_cnt), 32'd1);
        chk("nt_taken",       32'(taken_cnt), 32'd1);
        exp_t  = 1;
        exp_nt = 1;

        // Condition table with latency and load target
        for (int i = 0; i < int'(NVEC); i++) begin
            v = VEC[i];
            t = {v, ~v};
            run_jump(v[6:4], v[3:0], t, saw, tl, cyc);
            chk($sformatf("tbl%0d_taken", i), 32'(saw), 32'(v[7]));
            chk($sformatf("tbl%0d_lat", i), 32'(cyc), v[7] ? 32'd5 : 32'd2);
            if (v[7]) begin
                chk($sformatf("tbl%0d_tgt", i), 32'(tl), 32'(t));
                exp_t++;
            end else begin
                exp_nt++;
            end
        end
        chk("tbl_taken_cnt",    32'(taken_cnt), 32'(exp_t));
        chk("tbl_nottaken_cnt", 32'(nottaken_cnt), 32'(exp_nt));

        // Back-to-back: valid held high with always-taken
        jmp_cond  = 3'b000;
        jmp_valid = 1'b1;
        acc       = 0;
        loads     = 0;
        last_acc  = -1;
        for (int i = 0; i < 30; i++) begin
            if (jmp_ready) begin
                acc++;
                if (last_acc >= 0) chk("b2b_gap", 32'(i - last_acc), 32'd5);
                last_acc = i;
            end
            if (pc_load) loads++;
            @(negedge clk);
        end
        jmp_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd6);
        chk("b2b_loads",   32'(loads), 32'd6);
        chk("b2b_taken",   32'(taken_cnt), 32'(exp_t + 6));

        // Reset during LOAD, then accept on the first edge after release
        wait_ready("pre_rst");
        jmp_cond   = 3'b000;
        jmp_target = 16'hBEEF;
        jmp_valid  = 1'b1;
        @(negedge clk);
        jmp_valid = 1'b0;
        @(negedge clk);
        chk("rm_load_before", 32'(pc_load), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_load",     32'(pc_load), 32'd0);
        chk("rm_flush",    32'(flush_req), 32'd0);
        chk("rm_hold",     32'(condjmp_hold), 32'd0);
        chk("rm_target",   32'(pc_target), 32'd0);
        chk("rm_taken",    32'(taken_cnt), 32'd0);
        chk("rm_nottaken", 32'(nottaken_cnt), 32'd0);
        @(negedge clk);
        chk("rm_no_load", 32'(pc_load), 32'd0);
        reset_n    = 1'b1;
        jmp_target = 16'h5555;
        jmp_valid  = 1'b1;
        chk("rm_ready_after", 32'(jmp_ready), 32'd1);
        @(negedge clk);
        jmp_valid = 1'b0;
        chk("rm_first_accept", 32'(condjmp_hold), 32'd1);
        @(negedge clk);
        chk("rm_load_new",   32'(pc_load), 32'd1);
        chk("rm_target_new", 32'(pc_target), 32'h5555);
        wait_ready("rm_done");
        chk("rm_taken_new", 32'(taken_cnt), 32'd1);

        // Saturation: 300 taken jumps since reset
        for (int i = 0; i < 299; i++) begin
            run_jump(3'b000, 4'b0000, 16'h0100, saw, tl, cyc);
        end
        chk("sat_taken", 32'(taken_cnt), 32'd255);
        // 301st increment coincident with clear
        jmp_cond  = 3'b000;
        jmp_valid = 1'b1;
        @(negedge clk);
        jmp_valid = 1'b0;
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        chk("clr_taken",     32'(taken_cnt), 32'd0);
        chk("clr_load_still", 32'(pc_load), 32'd1);
        wait_ready("clr_done");
        chk("clr_taken_after", 32'(taken_cnt), 32'd0);
        run_jump(3'b111, 4'b1111, 16'h0200, saw, tl, cyc);
        chk("post_clr_nt",    32'(nottaken_cnt), 32'd1);
        chk("post_clr_taken", 32'(taken_cnt), 32'd0);

        // FLUSH_CYCLES=0 instance: never-taken then always-taken
        jmp_cond    = 3'b111;
        jmp_target  = 16'h7777;
        jmp_valid_z = 1'b1;
        chk("z_ready", 32'(jmp_ready_z), 32'd1);
        @(negedge clk);
        jmp_valid_z = 1'b0;
        chk("z_nv_hold", 32'(condjmp_hold_z), 32'd1);
        chk("z_nv_load", 32'(pc_load_z), 32'd0);
        @(negedge clk);
        chk("z_nv_load2",  32'(pc_load_z), 32'd0);
        chk("z_nv_ready",  32'(jmp_ready_z), 32'd1);
        chk("z_nv_cnt",    32'(nottaken_cnt_z), 32'd1);
        jmp_cond    = 3'b000;
        jmp_target  = 16'h3C3C;
        jmp_valid_z = 1'b1;
        @(negedge clk);
        jmp_valid_z = 1'b0;
        chk("z_al_k1_hold", 32'(condjmp_hold_z), 32'd1);
        chk("z_al_k1_load", 32'(pc_load_z), 32'd0);
        @(negedge clk);
        chk("z_al_k2_load",  32'(pc_load_z), 32'd1);
        chk("z_al_k2_flush", 32'(flush_req_z), 32'd1);
        chk("z_al_k2_tgt",   32'(pc_target_z), 32'h3C3C);
        @(negedge clk);
        chk("z_al_k3_ready", 32'(jmp_ready_z), 32'd1);
        chk("z_al_k3_hold",  32'(condjmp_hold_z), 32'd0);
        chk("z_al_k3_load",  32'(pc_load_z), 32'd0);
        chk("z_al_taken",    32'(taken_cnt_z), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uc_cndjmp_issue.md
UC_CNDJMP_ISSUE -- requirements
Module: uc_cndjmp_issue

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, pipeline-hold cycles after a taken jump, legal range 0..7.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port jmp_valid  input  1  decode stage presents a conditional-jump request.
REQ-006 SHALL have port jmp_ready  output  1  block can accept a request.
REQ-007 SHALL have port jmp_cond  input  3  condition code.
REQ-008 SHALL have port jmp_target  input  ADDR_W  jump destination.
REQ-009 SHALL have port flags  input  4  ALU flags {N,V,C,Z}, bit 3 = N, bit 0 = Z.
REQ-010 SHALL have port pc_load  output  1  one-cycle strobe: PC loads pc_target.
REQ-011 SHALL have port pc_target  output  ADDR_W  captured jump destination.
REQ-012 SHALL have port flush_req  output  1  one-cycle strobe, coincident with pc_load: invalidate fetch/decode.
REQ-013 SHALL have port condjmp_hold  output  1  pipeline stall while a jump is being resolved or flushed.
REQ-014 SHALL have port clr_stats  input  1  synchronous clear of statistics counters.
REQ-015 SHALL have port taken_cnt  output  8  count of taken jumps, saturating.
REQ-016 SHALL have port nottaken_cnt  output  8  count of not-taken jumps, saturating.

Function
REQ-017 SHALL accept a request on a rising edge where jmp_valid and jmp_ready are both 1, capturing jmp_cond, jmp_target and flags on that edge.
REQ-018 SHALL implement FSM states IDLE, RESOLVE, LOAD, HOLD; jmp_ready = 1 only in IDLE.
REQ-019 SHALL transition IDLE->RESOLVE on accept, else remain in IDLE.
REQ-020 SHALL evaluate the condition from captured values during RESOLVE: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 V, 111 never.
REQ-021 SHALL transition RESOLVE->LOAD if taken, RESOLVE->IDLE if not taken.
REQ-022 SHALL assert pc_load and flush_req for exactly the one LOAD cycle, with pc_target holding the captured target.
REQ-023 SHALL transition LOAD->HOLD when FLUSH_CYCLES>0, and LOAD->IDLE when FLUSH_CYCLES=0.
REQ-024 SHALL remain in HOLD for exactly FLUSH_CYCLES cycles using a down counter loaded with FLUSH_CYCLES on LOAD entry, then go to IDLE.
REQ-025 SHALL assert condjmp_hold combinationally whenever the state is RESOLVE, LOAD or HOLD, and deassert it in IDLE.
REQ-026 SHALL give cycle-level latency from accept edge k as follows: taken -> pc_load high in cycle k+2, IDLE at cycle k+3+FLUSH_CYCLES; not taken -> IDLE in cycle k+2.
REQ-027 SHALL ignore jmp_valid while not in IDLE; no request is queued.
REQ-028 SHALL increment taken_cnt on RESOLVE->LOAD and nottaken_cnt on RESOLVE->IDLE, each saturating at 255 (no wrap).
REQ-029 SHALL give clr_stats priority when it coincides with an increment: the counter becomes 0.
REQ-030 SHALL hold pc_target at its last captured value outside LOAD.
REQ-031 SHALL NOT change the captured flags during RESOLVE if the flags input changes after acceptance.

Reset
REQ-032 SHALL, on reset_n low, immediately and asynchronously force state IDLE, pc_load=0, flush_req=0, condjmp_hold=0, pc_target=0, taken_cnt=0, nottaken_cnt=0, and hold counter 0.
REQ-033 SHALL abandon a jump in progress on reset mid-operation with no pc_load issued; jmp_ready=1 on the first cycle after reset_n rises.
REQ-034 SHALL permit acceptance on the first rising edge with reset_n high.

Verification
REQ-035 SHALL cover a taken jump: cond=001, flags=0001, target=0x1234, FLUSH_CYCLES=2 -> pc_load/flush_req high in cycle k+2 with pc_target=0x1234, hold high k+1..k+4, jmp_ready high at k+5, taken_cnt=1.
REQ-036 SHALL cover a not-taken jump: cond=010, flags=0001 -> no pc_load, hold high only in cycle k+1, nottaken_cnt=1, jmp_ready high at k+2.
REQ-037 SHALL cover back-to-back requests: jmp_valid held high continuously with cond=000 -> accepts every 5 cycles (FLUSH_CYCLES=2), none lost or duplicated.
REQ-038 SHALL cover reset mid-operation: reset_n low during LOAD -> pc_load drops immediately, all outputs zero, jmp_ready=1 after release.
REQ-039 SHALL cover saturation: 300 taken jumps -> taken_cnt=255; clr_stats coincident with the 301st increment -> 0.
REQ-040 SHALL cover FLUSH_CYCLES=0 with cond=111 and cond=000 -> never-taken leaves pc_load low; always-taken returns to IDLE in k+3.
